des_key_sched_seq: RTL and testbench

//  Iterative, handshaked DES key schedule: accepts one key, streams the 16 48-bit round keys over a

---
 rtl/des_key_sched_seq.sv | 212 +++++++++++++++++++++
 tb/tb_des_key_sched_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq
//   Iterative DES key schedule with a valid/ready output stream. One key is
//   loaded per schedule; the 16 48-bit round keys are streamed RPC per beat,
//   in encrypt order (K1..K16) or decrypt order (K16..K1).
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start, decrypt  load request (taken when key_ready) and order select
//   key_in          KEY_W-bit key: 64 = raw DES key, 56 = C0||D0 already PC-1'd
//   abort           cancels a running schedule (no done pulse)
//   key_ready       high while idle
//   rk_valid/ready  round-key beat handshake
//   rk_data         RPC round keys, first key of the beat in the MSBs
//   rk_idx          round number (0..15) of the first key of the beat
//   rk_last         final beat of the schedule
//   done            one-cycle pulse after the final beat is accepted
module des_key_sched_seq #(
  parameter int KEY_W = 56,
  parameter int RPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 decrypt,
  input  logic [KEY_W-1:0]     key_in,
  input  logic                 abort,
  output logic                 key_ready,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [48*RPC-1:0]    rk_data,
  output logic [3:0]           rk_idx,
  output logic                 rk_last,
  output logic                 done
);

  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
      $error("des_key_sched_seq: RPC must be 1, 2 or 4");
    end
    if (!(KEY_W == 56 || KEY_W == 64)) begin : g_bad_keyw
      $error("des_key_sched_seq: KEY_W must be 56 or 64");
    end
  endgenerate

  // Permutation tables, FIPS 46-3 bit numbering (bit 1 = MSB).
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return r;
  endfunction

  // Shift amount of round k+1 (k = 0-based round index).
  function automatic logic [1:0] shamt(input logic [3:0] k);
    return (k == 4'd0 || k == 4'd1 || k == 4'd8 || k == 4'd15) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                        input logic left);
    logic [27:0] r;
    case (amt)
      2'd1:    r = left ? {x[26:0], x[27]}    : {x[0], x[27:1]};
      2'd2:    r = left ? {x[25:0], x[27:26]} : {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  // One round step away from round index k. Encrypt moves to k+1 rotating left
  // by that round's shift; the step out of round 16 rotates by 0 so a finished
  // schedule leaves C0/D0 in the registers. Decrypt moves to k-1 rotating right
  // by round k's shift, which lands on C0/D0 after the final step as well.
  function automatic logic [55:0] step(input logic [55:0] cd, input logic dec,
                                       input logic [3:0] k);
    logic [1:0] amt;
    if (dec) amt = shamt(k);
    else     amt = (k == 4'd15) ? 2'd0 : shamt(4'(k + 4'd1));
    return {rot28(cd[55:28], amt, !dec), rot28(cd[27:0], amt, !dec)};
  endfunction

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic        dec_q, dec_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  idx_q, idx_d;
  logic        key_ready_q, key_ready_d;
  logic        rk_valid_q, rk_valid_d;
  logic        done_q, done_d;

  logic [55:0] load_cd;

  generate
    if (KEY_W == 64) begin : g_pc1
      logic unused_parity;
      assign load_cd       = pc1(key_in);
      assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8], key_in[0]};
    end else begin : g_raw
      assign load_cd = key_in[55:0];
    end
  endgenerate

  // Unrolled round steps: element j is the C/D state of the j-th key in the
  // current beat; element RPC is the state for the next beat.
  logic [55:0]       cd_chain  [RPC+1];
  logic [3:0]        idx_chain [RPC+1];
  logic [48*RPC-1:0] keys_raw;

  assign cd_chain[0]  = cd_q;
  assign idx_chain[0] = idx_q;

  generate
    for (genvar gi = 0; gi < RPC; gi++) begin : g_step
      assign cd_chain[gi+1]  = step(cd_chain[gi], dec_q, idx_chain[gi]);
      assign idx_chain[gi+1] = dec_q ? 4'(idx_chain[gi] - 4'd1) : 4'(idx_chain[gi] + 4'd1);
      assign keys_raw[48*(RPC-gi)-1 -: 48] = pc2(cd_chain[gi]);
    end
  endgenerate

  logic last_beat;
  assign last_beat = dec_q ? (idx_q == 4'(RPC - 1)) : (idx_q == 4'(16 - RPC));

  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    cd_d        = cd_q;
    idx_d       = idx_q;
    key_ready_d = key_ready_q;
    rk_valid_d  = rk_valid_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          dec_d       = decrypt;
          // Encrypt starts at round 1 (one left shift); decrypt at round 16,
          // whose C16/D16 equals C0/D0.
          cd_d        = decrypt ? load_cd
                                : {rot28(load_cd[55:28], 2'd1, 1'b1),
                                   rot28(load_cd[27:0], 2'd1, 1'b1)};
          idx_d       = decrypt ? 4'd15 : 4'd0;
          key_ready_d = 1'b0;
          rk_valid_d  = 1'b1;
        end
      end
      S_RUN: begin
        // abort wins over a handshake in the same cycle
        if (abort) begin
          state_d     = S_IDLE;
          key_ready_d = 1'b1;
          rk_valid_d  = 1'b0;
        end else if (rk_ready) begin
          cd_d  = cd_chain[RPC];
          idx_d = idx_chain[RPC];
          if (last_beat) begin
            state_d     = S_IDLE;
            key_ready_d = 1'b1;
            rk_valid_d  = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dec_q       <= 1'b0;
      cd_q        <= '0;
      idx_q       <= '0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      cd_q        <= cd_d;
      idx_q       <= idx_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      done_q      <= done_d;
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_data   = rk_valid_q ? keys_raw : '0;
  assign rk_idx    = idx_q;
  assign rk_last   = rk_valid_q && last_beat;
  assign done      = done_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Bench for des_key_sched_seq: unit 0 = KEY_W 64 / RPC 1, unit 1 = KEY_W 56 / RPC 4
// (fed the PC-1 of the same key). A plain DES key-schedule model produces the
// expected stream; a compare process checks every cycle.
module tb_des_key_sched_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, decrypt = 1'b0, abort = 1'b0, rk_ready = 1'b0;
  logic [63:0]   key_a = 64'd0;
  logic [55:0]   key_b;

  logic          a_key_ready, a_rk_valid, a_rk_last, a_done;
  logic [47:0]   a_rk_data;
  logic [3:0]    a_rk_idx;
  logic          b_key_ready, b_rk_valid, b_rk_last, b_done;
  logic [191:0]  b_rk_data;
  logic [3:0]    b_rk_idx;

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2    = 64'h0E329232EA6D0D73;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int RPC_U [2] = '{1, 4};

  function automatic logic [55:0] m_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] m_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return r;
  endfunction

  // Textbook schedule: K(i+1) stored at bits [i*48 +: 48].
  function automatic logic [767:0] m_sched(input logic [63:0] k);
    logic [55:0]  cd;
    logic [27:0]  c, d;
    logic [767:0] r;
    cd = m_pc1(k);
    c  = cd[55:28];
    d  = cd[27:0];
    r  = '0;
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      r[i*48 +: 48] = m_pc2({c, d});
    end
    return r;
  endfunction

  assign key_b = m_pc1(key_a);

  des_key_sched_seq #(.KEY_W(64), .RPC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_a),
    .abort(abort), .key_ready(a_key_ready), .rk_valid(a_rk_valid), .rk_ready(rk_ready),
    .rk_data(a_rk_data), .rk_idx(a_rk_idx), .rk_last(a_rk_last), .done(a_done));

  des_key_sched_seq #(.KEY_W(56), .RPC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_b),
    .abort(abort), .key_ready(b_key_ready), .rk_valid(b_rk_valid), .rk_ready(rk_ready),
    .rk_data(b_rk_data), .rk_idx(b_rk_idx), .rk_last(b_rk_last), .done(b_done));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input int u, input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s at %0t: got %0h expected %0h", u, nm, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit           m_active [2] = '{0, 0};
  bit           m_dec    [2] = '{0, 0};
  int           m_beat   [2] = '{0, 0};
  bit           m_done   [2] = '{0, 0};
  logic [767:0] m_keys   [2] = '{768'd0, 768'd0};

  always @(posedge clk or negedge rst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_active[u] <= 1'b0;
        m_done[u]   <= 1'b0;
        m_beat[u]   <= 0;
      end else begin
        m_done[u] <= 1'b0;
        if (!m_active[u]) begin
          if (start) begin
            m_active[u] <= 1'b1;
            m_dec[u]    <= decrypt;
            m_beat[u]   <= 0;
            m_keys[u]   <= m_sched(key_a);
          end
        end else if (abort) begin
          m_active[u] <= 1'b0;
        end else if (rk_ready) begin
          m_beat[u] <= m_beat[u] + 1;
          if (m_beat[u] + 1 == 16 / RPC_U[u]) begin
            m_active[u] <= 1'b0;
            m_done[u]   <= 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [191:0] exp_data(input int u);
    logic [191:0] r;
    int kidx;
    r = '0;
    for (int j = 0; j < RPC_U[u]; j++) begin
      kidx = m_dec[u] ? 15 - m_beat[u] * RPC_U[u] - j : m_beat[u] * RPC_U[u] + j;
      r = {r[143:0], m_keys[u][kidx*48 +: 48]};
    end
    return r;
  endfunction

  task automatic check_unit(input int u, input logic v, input logic [191:0] d,
                            input logic [3:0] ix, input logic l, input logic kr,
                            input logic dn);
    int e_idx;
    chk(u, "key_ready", kr, !m_active[u]);
    chk(u, "done", dn, m_done[u]);
    chk(u, "rk_valid", v, m_active[u]);
    if (m_active[u]) begin
      e_idx = m_dec[u] ? 15 - m_beat[u] * RPC_U[u] : m_beat[u] * RPC_U[u];
      chk(u, "rk_data", d, exp_data(u));
      chk(u, "rk_idx", ix, e_idx);
      chk(u, "rk_last", l, m_beat[u] == 16 / RPC_U[u] - 1);
    end else if (!rst_n) begin
      chk(u, "rst rk_data", d, 0);
      chk(u, "rst rk_idx", ix, 0);
      chk(u, "rst rk_last", l, 0);
    end
  endtask

  always @(negedge clk) begin
    check_unit(0, a_rk_valid, {144'd0, a_rk_data}, a_rk_idx, a_rk_last, a_key_ready, a_done);
    check_unit(1, b_rk_valid, b_rk_data, b_rk_idx, b_rk_last, b_key_ready, b_done);
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic literal_checks(input logic [63:0] k, input bit dec);
    if (k == KEY_REF && a_rk_valid) begin
      if (!dec && a_rk_idx == 4'd0) chk(0, "lit enc K1", a_rk_data, 48'h1B02EFFC7072);
      if (!dec && a_rk_idx == 4'd1) chk(0, "lit enc K2", a_rk_data, 48'h79AED9DBC9E5);
      if (!dec && a_rk_idx == 4'd15) begin
        chk(0, "lit enc K16", a_rk_data, 48'hCB3D8B0E17F5);
        chk(0, "lit enc last", a_rk_last, 1);
      end
      if (dec && a_rk_idx == 4'd15) chk(0, "lit dec first", a_rk_data, 48'hCB3D8B0E17F5);
      if (dec && a_rk_idx == 4'd0) begin
        chk(0, "lit dec K1", a_rk_data, 48'h1B02EFFC7072);
        chk(0, "lit dec last", a_rk_last, 1);
      end
    end
    if (k == KEY_REF && !dec && b_rk_valid) begin
      if (b_rk_idx == 4'd0) chk(1, "lit rpc4 beat0", b_rk_data[191:144], 48'h1B02EFFC7072);
      if (b_rk_idx == 4'd12) begin
        chk(1, "lit rpc4 beat3", b_rk_data[47:0], 48'hCB3D8B0E17F5);
        chk(1, "lit rpc4 last", b_rk_last, 1);
      end
    end
  endtask

  task automatic run_sched(input logic [63:0] k, input bit dec, input bit rnd,
                           input int abort_at);
    int beats;
    bit fin;
    beats    = 0;
    fin      = 0;
    key_a    = k;
    decrypt  = dec;
    start    = 1'b1;
    rk_ready = 1'b1;
    tick;
    start = 1'b0;
    chk(0, "latency rk_valid", a_rk_valid, 1);
    for (int c = 0; c < 400 && !fin; c++) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && beats == abort_at && a_rk_valid) begin
        rk_ready = 1'b1;
        abort    = 1'b1;
      end
      literal_checks(k, dec);
      if (a_rk_valid && rk_ready && !abort) beats++;
      tick;
      if (abort) begin
        abort = 1'b0;
        fin   = 1;
        chk(0, "abort rk_valid", a_rk_valid, 0);
        chk(0, "abort done", a_done, 0);
      end
      if (a_done) fin = 1;
    end
    if (!fin) chk(0, "schedule timeout", 0, 1);
    if (abort_at < 0) chk(0, "beat count", beats, 16);
    else              chk(0, "beats before abort", beats, abort_at);
  endtask

  initial begin
    logic [767:0] ks;
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;

    ks = m_sched(KEY_REF);
    chk(0, "model K1", ks[47:0], 48'h1B02EFFC7072);
    chk(0, "model K2", ks[95:48], 48'h79AED9DBC9E5);
    chk(0, "model K16", ks[767:720], 48'hCB3D8B0E17F5);

    run_sched(KEY_REF, 0, 0, -1);
    chk(0, "cd restored", dut_a.cd_q, m_pc1(KEY_REF));
    chk(1, "cd restored", dut_b.cd_q, m_pc1(KEY_REF));
    run_sched(KEY_REF, 1, 0, -1);           // started in the done cycle
    chk(0, "cd restored dec", dut_a.cd_q, m_pc1(KEY_REF));
    run_sched(KEY2, 0, 1, -1);
    run_sched(KEY2, 1, 1, -1);

    abort = 1'b1;                            // ignored while idle
    tick;
    abort = 1'b0;
    tick;

    run_sched(KEY_REF, 0, 0, 5);
    run_sched(KEY_REF, 0, 0, -1);            // restart right after abort

    key_a   = KEY2;
    decrypt = 1'b0;
    start   = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    #1 rst_n = 1'b0;
    #1;
    chk(0, "async rst key_ready", a_key_ready, 1);
    chk(0, "async rst rk_valid", a_rk_valid, 0);
    chk(0, "async rst rk_data", a_rk_data, 0);
    chk(0, "async rst rk_idx", a_rk_idx, 0);
    chk(0, "async rst done", a_done, 0);
    chk(1, "async rst key_ready", b_key_ready, 1);
    chk(1, "async rst rk_data", b_rk_data, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;

    run_sched(KEY2, 0, 1, -1);
    repeat (2) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
